// File: rtl/spi_pkg.sv
// Shared definitions for the SPI link: default word length, idle line levels
// and the receiver state encoding.
package spi_pkg;

  localparam int   DATA_W_DEF = 16;
  localparam logic CS_IDLE    = 1'b1;
  localparam logic SCLK_IDLE  = 1'b0;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_DONE  = 2'd2
  } spi_state_e;

endpackage

// File: rtl/spi_sync.sv
// Multi-flop synchroniser for one asynchronous serial input, resetting to a
// chosen idle level so no spurious edge is seen when reset releases.
module spi_sync #(
  parameter int   STAGES  = 2,
  parameter logic RST_VAL = 1'b0
) (
  input  logic clk,
  input  logic reset,
  input  logic d,
  output logic q
);

  logic [STAGES-1:0] sync_r;

  // Shift chain; the oldest stage is the synchronised output.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sync_r <= {STAGES{RST_VAL}};
    end else begin
      sync_r <= {sync_r[STAGES-2:0], d};
    end
  end

  assign q = sync_r[STAGES-1];

endmodule

// File: rtl/spi_slave_rx.sv
// SPI receive end: oversamples the serial pins, deserialises MSB-first words
// and presents them through a one-deep valid/ready holding register.
module spi_slave_rx
  import spi_pkg::*;
#(
  parameter int DATA_W      = DATA_W_DEF,
  parameter int SYNC_STAGES = 2,
  parameter int TIMEOUT     = 64
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    spi_cs_l,
  input  logic                    spi_clk,
  input  logic                    spi_data,
  output logic [DATA_W-1:0]       rx_data,
  output logic                    rx_valid,
  input  logic                    rx_ready,
  output logic                    overrun,
  input  logic                    overrun_clr,
  output logic                    frame_err,
  output logic [$clog2(DATA_W):0] bit_count
);

  localparam int CNT_W = $clog2(DATA_W) + 1;
  localparam int TMO_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

  logic              cs_s, sclk_s, data_s;
  logic              sclk_prev_r;
  logic              strobe_s;
  spi_state_e        state_r, state_n;
  logic [DATA_W-1:0] shift_r, shift_n;
  logic [CNT_W-1:0]  cnt_r, cnt_n;
  logic [TMO_W-1:0]  tmo_r, tmo_n;
  logic              frame_err_n;
  logic              word_done_s;
  logic              load_s, ovr_set_s;

  spi_sync #(.STAGES(SYNC_STAGES), .RST_VAL(CS_IDLE)) u_sync_cs (
    .clk(clk), .reset(reset), .d(spi_cs_l), .q(cs_s)
  );
  spi_sync #(.STAGES(SYNC_STAGES), .RST_VAL(SCLK_IDLE)) u_sync_clk (
    .clk(clk), .reset(reset), .d(spi_clk), .q(sclk_s)
  );
  spi_sync #(.STAGES(SYNC_STAGES), .RST_VAL(1'b0)) u_sync_data (
    .clk(clk), .reset(reset), .d(spi_data), .q(data_s)
  );

  // Previous synchronised serial clock, for rising-edge detection.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sclk_prev_r <= SCLK_IDLE;
    end else begin
      sclk_prev_r <= sclk_s;
    end
  end

  // cs_l may go high between bits, so it only gates the strobe.
  assign strobe_s = sclk_s & ~sclk_prev_r & ~cs_s;

  // Next-state logic: bit capture, count-based framing and inactivity timeout.
  always_comb begin
    state_n     = state_r;
    shift_n     = shift_r;
    cnt_n       = cnt_r;
    tmo_n       = tmo_r;
    frame_err_n = 1'b0;
    word_done_s = 1'b0;
    case (state_r)
      ST_IDLE: begin
        if (strobe_s) begin
          shift_n = {shift_r[DATA_W-2:0], data_s};
          cnt_n   = CNT_W'(DATA_W - 1);
          tmo_n   = {TMO_W{1'b0}};
          state_n = ST_SHIFT;
        end else begin
          tmo_n   = {TMO_W{1'b0}};
        end
      end
      ST_SHIFT: begin
        if (strobe_s) begin
          shift_n = {shift_r[DATA_W-2:0], data_s};
          cnt_n   = cnt_r - CNT_W'(1);
          tmo_n   = {TMO_W{1'b0}};
          if (cnt_r == CNT_W'(1)) begin
            state_n = ST_DONE;
          end else begin
            state_n = ST_SHIFT;
          end
        end else if (tmo_r == TMO_W'(TIMEOUT - 1)) begin
          frame_err_n = 1'b1;
          shift_n     = {DATA_W{1'b0}};
          cnt_n       = CNT_W'(DATA_W);
          tmo_n       = {TMO_W{1'b0}};
          state_n     = ST_IDLE;
        end else begin
          tmo_n = tmo_r + TMO_W'(1);
        end
      end
      ST_DONE: begin
        word_done_s = 1'b1;
        shift_n     = {DATA_W{1'b0}};
        cnt_n       = CNT_W'(DATA_W);
        tmo_n       = {TMO_W{1'b0}};
        state_n     = ST_IDLE;
      end
      default: begin
        shift_n = {DATA_W{1'b0}};
        cnt_n   = CNT_W'(DATA_W);
        tmo_n   = {TMO_W{1'b0}};
        state_n = ST_IDLE;
      end
    endcase
  end

  // Receiver state registers.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_r   <= ST_IDLE;
      shift_r   <= {DATA_W{1'b0}};
      cnt_r     <= CNT_W'(DATA_W);
      tmo_r     <= {TMO_W{1'b0}};
      frame_err <= 1'b0;
    end else begin
      state_r   <= state_n;
      shift_r   <= shift_n;
      cnt_r     <= cnt_n;
      tmo_r     <= tmo_n;
      frame_err <= frame_err_n;
    end
  end

  assign bit_count = cnt_r;

  // A word may load whenever the slot empties in the same cycle.
  assign load_s    = word_done_s & (~rx_valid | rx_ready);
  assign ovr_set_s = word_done_s & rx_valid & ~rx_ready;

  // Holding register, handshake and sticky overrun (set beats clear).
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rx_data  <= {DATA_W{1'b0}};
      rx_valid <= 1'b0;
      overrun  <= 1'b0;
    end else begin
      if (load_s) begin
        rx_data  <= shift_r;
        rx_valid <= 1'b1;
      end else if (rx_valid && rx_ready) begin
        rx_valid <= 1'b0;
      end else begin
        rx_valid <= rx_valid;
      end
      if (ovr_set_s) begin
        overrun <= 1'b1;
      end else if (overrun_clr) begin
        overrun <= 1'b0;
      end else begin
        overrun <= overrun;
      end
    end
  end

endmodule
